// File: rtl/tsen_ctrl_pkg.sv
// rtl/tsen_ctrl_pkg.sv - register offsets, STATUS bit positions and FSM states for tsen_ctrl
package tsen_ctrl_pkg;

    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_WINDOW  = 'h04;
    localparam int OFF_STATUS  = 'h08;
    localparam int OFF_RESULT  = 'h0C;
    localparam int OFF_THRESH  = 'h10;
    localparam int OFF_INTR_EN = 'h14;
    localparam int OFF_AVG     = 'h18;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_ALARM = 3;

    localparam int WINDOW_RST = 1000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/tsen_pulse_sync.sv
// rtl/tsen_pulse_sync.sv - 2-FF synchroniser plus registered rising-edge detect (pulse 3 cycles after the edge)
module tsen_pulse_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta, r_sync, r_prev, r_pulse;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/tsen_ctrl.sv
// rtl/tsen_ctrl.sv - temperature sensor controller: settle, windowed edge count, alarm and interrupt
// Optional TSEN_CTRL_AVG_EN adds a 4-entry RESULT history with its average readable at 0x18.
module tsen_ctrl
    import tsen_ctrl_pkg::*;
#(
    parameter int AW         = 8,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o,
    output logic          error_o,
    input  logic          sens_osc_i,
    output logic          sens_en_o,
    output logic          intr_o
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e r_state, w_state_nxt;
    logic [CNT_W-1:0] r_window, r_thresh, r_result, r_win, r_tmr, r_cnt;
    logic [SW-1:0]    r_settle;
    logic             r_cont, r_sens_en, r_ovf_int, r_done, r_ovf, r_alarm, r_intr;
    logic [1:0]       r_intr_en;

    logic             w_pulse;
    logic [AW-1:0]    w_off;
    logic             w_sel_ctrl, w_sel_window, w_sel_status, w_sel_result;
    logic             w_sel_thresh, w_sel_intr_en, w_sel_avg, w_mapped, w_ro;
    logic [31:0]      w_bmask;
    logic [CNT_W-1:0] w_wmask, w_wdat, w_win_eff, w_avg;
    logic             w_start, w_w1c, w_done_set;
    logic [3:0]       w_status;
    logic             w_unused;

    tsen_pulse_sync u_sync (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_async (sens_osc_i),
        .o_pulse (w_pulse)
    );

    assign w_off         = {addr_i[AW-1:2], 2'b00};
    assign w_sel_ctrl    = (w_off == AW'(OFF_CTRL));
    assign w_sel_window  = (w_off == AW'(OFF_WINDOW));
    assign w_sel_status  = (w_off == AW'(OFF_STATUS));
    assign w_sel_result  = (w_off == AW'(OFF_RESULT));
    assign w_sel_thresh  = (w_off == AW'(OFF_THRESH));
    assign w_sel_intr_en = (w_off == AW'(OFF_INTR_EN));
    assign w_mapped = w_sel_ctrl | w_sel_window | w_sel_status | w_sel_result |
                      w_sel_thresh | w_sel_intr_en | w_sel_avg;
    assign w_ro     = w_sel_result | w_sel_avg;
    assign error_o  = (re_i | we_i) & (~w_mapped | (we_i & w_ro));

    assign w_bmask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign w_wmask   = w_bmask[CNT_W-1:0];
    assign w_wdat    = wdata_i[CNT_W-1:0];
    assign w_win_eff = (r_window == '0) ? CNT_ONE : r_window;
    assign w_start   = we_i & w_sel_ctrl & be_i[0] & wdata_i[0];
    assign w_w1c     = we_i & w_sel_status & be_i[0];
    assign w_done_set = (r_state == S_DONE);
    assign w_unused  = ^{addr_i[1:0], wdata_i, w_bmask};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (r_settle == SETTLE_LAST) w_state_nxt = S_MEASURE;
            S_MEASURE: if (r_tmr == r_win - CNT_ONE) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = r_cont ? S_MEASURE : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_win     <= '0;
            r_tmr     <= '0;
            r_cnt     <= '0;
            r_settle  <= '0;
            r_ovf_int <= 1'b0;
            r_sens_en <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_win     <= w_win_eff;
                    r_cnt     <= '0;
                    r_tmr     <= '0;
                    r_settle  <= '0;
                    r_ovf_int <= 1'b0;
                    r_sens_en <= 1'b1;
                end
                S_SETTLE: r_settle <= r_settle + SW'(1);
                S_MEASURE: begin
                    r_tmr <= r_tmr + CNT_ONE;
                    if (w_pulse) begin
                        if (r_cnt == '1) r_ovf_int <= 1'b1;
                        else             r_cnt     <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_result <= r_cnt;
                    // Continuous mode keeps the sensor powered and skips the settle phase.
                    if (r_cont) begin
                        r_win     <= w_win_eff;
                        r_cnt     <= '0;
                        r_tmr     <= '0;
                        r_ovf_int <= 1'b0;
                    end else begin
                        r_sens_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_window  <= CNT_W'(WINDOW_RST);
            r_thresh  <= '0;
            r_cont    <= 1'b0;
            r_intr_en <= 2'b00;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_alarm   <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            if (we_i && w_sel_window) r_window <= (r_window & ~w_wmask) | (w_wdat & w_wmask);
            if (we_i && w_sel_thresh) r_thresh <= (r_thresh & ~w_wmask) | (w_wdat & w_wmask);
            if (we_i && w_sel_ctrl && be_i[0])    r_cont    <= wdata_i[1];
            if (we_i && w_sel_intr_en && be_i[0]) r_intr_en <= wdata_i[1:0];
            // Hardware set takes priority over a simultaneous write-1-to-clear.
            r_done  <= w_done_set | (r_done & ~(w_w1c & wdata_i[ST_DONE]));
            r_ovf   <= (w_done_set & r_ovf_int) | (r_ovf & ~(w_w1c & wdata_i[ST_OVF]));
            r_alarm <= (w_done_set & (r_cnt > r_thresh)) |
                       (r_alarm & ~(w_w1c & wdata_i[ST_ALARM]));
            r_intr  <= (r_done & r_intr_en[0]) | (r_alarm & r_intr_en[1]);
        end
    end

`ifdef TSEN_CTRL_AVG_EN
    logic [CNT_W-1:0] r_hist [4];
    logic [CNT_W+1:0] w_sum;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
        end else if (w_done_set) begin
            r_hist[0] <= r_cnt;
            for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    assign w_sum = (CNT_W+2)'(r_hist[0]) + (CNT_W+2)'(r_hist[1]) +
                   (CNT_W+2)'(r_hist[2]) + (CNT_W+2)'(r_hist[3]);
    assign w_avg     = CNT_W'(w_sum >> 2);
    assign w_sel_avg = (w_off == AW'(OFF_AVG));
`else
    assign w_avg     = '0;
    assign w_sel_avg = 1'b0;
`endif

    assign w_status[ST_BUSY]  = (r_state != S_IDLE);
    assign w_status[ST_DONE]  = r_done;
    assign w_status[ST_OVF]   = r_ovf;
    assign w_status[ST_ALARM] = r_alarm;

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            if (w_sel_ctrl)         rdata_o = {30'b0, r_cont, 1'b0};
            else if (w_sel_window)  rdata_o = 32'(r_window);
            else if (w_sel_status)  rdata_o = {28'b0, w_status};
            else if (w_sel_result)  rdata_o = 32'(r_result);
            else if (w_sel_thresh)  rdata_o = 32'(r_thresh);
            else if (w_sel_intr_en) rdata_o = {30'b0, r_intr_en};
            else if (w_sel_avg)     rdata_o = 32'(w_avg);
        end
    end

    assign sens_en_o = r_sens_en;
    assign intr_o    = r_intr;

endmodule

// File: tb/tb_tsen_ctrl.sv
// tb/tb_tsen_ctrl.sv - self-checking bench for tsen_ctrl (register table plus timed measurement sequences)
module tb_tsen_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        osc = 1'b0;
    logic [31:0] rdata;
    logic        error, sens_en, intr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int osc_half = 0;
    int osc_ph = 0;

    tsen_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .re_i       (re),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .rdata_o    (rdata),
        .error_o    (error),
        .sens_osc_i (osc),
        .sens_en_o  (sens_en),
        .intr_o     (intr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator period is 2*osc_half clock cycles, stepped on the falling edge.
    always @(negedge clk) begin
        if (osc_half != 0) begin
            osc_ph = osc_ph + 1;
            if (osc_ph >= osc_half) begin
                osc_ph = 0;
                osc = ~osc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                             output logic err);
        we = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        err = error;
        @(posedge clk);
        #1;
        we = 1'b0; be = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] rd, output logic err);
        re = 1'b1; addr = a;
        @(negedge clk);
        rd = rdata;
        err = error;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int k);
        k = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (!sens_en) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output int t);
        logic [31:0] rd;
        logic        e;
        t = -1;
        for (int i = 0; i < max; i++) begin
            bus_read(8'h08, rd, e);
            if (rd[1]) begin
                t = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       nm;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          k, t1, t2;
        bit          avg_err;

`ifdef TSEN_CTRL_AVG_EN
        avg_err = 1'b0;
`else
        avg_err = 1'b1;
`endif
        vt[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,      1'b0, "rst_ctrl"};
        vt[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'd1000,   1'b0, "rst_window"};
        vt[2]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h0,      1'b0, "rst_status"};
        vt[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,      1'b0, "rst_result"};
        vt[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0,      1'b0, "rst_thresh"};
        vt[5]  = '{1'b0, 8'h14, 32'h0,        4'h0, 32'h0,      1'b0, "rst_intr_en"};
        vt[6]  = '{1'b0, 8'h18, 32'h0,        4'h0, 32'h0,      avg_err, "rd_18"};
        vt[7]  = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'h0,      1'b1, "rd_1c_unmapped"};
        vt[8]  = '{1'b1, 8'h10, 32'hAABB1234, 4'h1, 32'h0,      1'b0, "wr_thresh_b0"};
        vt[9]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h34,     1'b0, "rd_thresh_b0"};
        vt[10] = '{1'b1, 8'h10, 32'hFFFF56FF, 4'h2, 32'h0,      1'b0, "wr_thresh_b1"};
        vt[11] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h5634,   1'b0, "rd_thresh_b1"};
        vt[12] = '{1'b1, 8'h0C, 32'h1,        4'hF, 32'h0,      1'b1, "wr_result_ro"};
        vt[13] = '{1'b1, 8'h20, 32'h1,        4'hF, 32'h0,      1'b1, "wr_unmapped"};
        vt[14] = '{1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0,      1'b0, "wr_intr_en"};
        vt[15] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'h3,      1'b0, "rd_intr_en"};
        vt[16] = '{1'b1, 8'h14, 32'h0,        4'hF, 32'h0,      1'b0, "clr_intr_en"};
        vt[17] = '{1'b1, 8'h04, 32'h12340064, 4'hF, 32'h0,      1'b0, "wr_window"};
        vt[18] = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h64,     1'b0, "rd_window_lowbits"};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_sens_en", sens_en, 0);
        check("rst_intr", intr, 0);
        check("idle_rdata", rdata, 0);
        check("idle_error", error, 0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].w) begin
                bus_write(vt[i].a, vt[i].d, vt[i].b, e);
                check({vt[i].nm, "_err"}, e, vt[i].exp_err);
            end else begin
                bus_read(vt[i].a, rd, e);
                check({vt[i].nm, "_rd"}, rd, vt[i].exp_rd);
                check({vt[i].nm, "_err"}, e, vt[i].exp_err);
            end
        end

        // Single run, clk/8 oscillator, second START during SETTLE must be ignored.
        osc_half = 4;
        bus_write(8'h00, 32'h1, 4'h1, e);
        check("run_sens_en_on", sens_en, 1);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            if (i == 20) bus_write(8'h00, 32'h1, 4'h1, e);
            else begin
                @(posedge clk);
                #1;
            end
            if (!sens_en) begin
                k = i;
                break;
            end
        end
        check("run_busy_cycles", k, 165);
        bus_read(8'h0C, rd, e);
        check("run_result_range", (rd >= 12 && rd <= 13), 1);
        bus_read(8'h08, rd, e);
        check("run_status_done", rd[1:0], 2'b10);
        bus_write(8'h08, 32'hE, 4'h1, e);
        bus_read(8'h08, rd, e);
        check("w1c_all", rd, 0);

        // Alarm and interrupt, clk/4 oscillator gives exactly 25 edges in 100 cycles.
        bus_write(8'h10, 32'd10, 4'hF, e);
        bus_write(8'h14, 32'h2, 4'h1, e);
        osc_half = 2;
        bus_write(8'h00, 32'h1, 4'h1, e);
        wait_idle(300, k);
        check("alarm_busy_cycles", k, 165);
        check("intr_lag", intr, 0);
        bus_read(8'h0C, rd, e);
        check("alarm_result", rd, 25);
        check("intr_set", intr, 1);
        bus_read(8'h08, rd, e);
        check("alarm_status", rd[3], 1);
        bus_write(8'h08, 32'h8, 4'h1, e);
        check("intr_hold", intr, 1);
        @(posedge clk);
        #1;
        check("intr_clr", intr, 0);

        // Continuous mode: back-to-back windows without re-settle, then stop via CONT=0.
        bus_write(8'h08, 32'hE, 4'h1, e);
        bus_write(8'h14, 32'h0, 4'h1, e);
        bus_write(8'h04, 32'd40, 4'hF, e);
        bus_write(8'h00, 32'h3, 4'h1, e);
        wait_done(300, t1);
        bus_write(8'h08, 32'h2, 4'h1, e);
        wait_done(100, t2);
        check("cont_found", (t1 >= 0 && t2 >= 0), 1);
        check("cont_period", t2 - t1, 41);
        bus_read(8'h0C, rd, e);
        check("cont_result", rd, 10);
        bus_read(8'h08, rd, e);
        check("cont_busy", rd[0], 1);
        bus_write(8'h00, 32'h0, 4'h1, e);
        check("cont_stop_sens_en", sens_en, 1);
        wait_idle(60, k);
        check("cont_stop_idle", (k > 0), 1);
        bus_read(8'h08, rd, e);
        check("cont_stop_status", rd[1:0], 2'b10);

        // Reset mid-measurement discards everything.
        osc_half = 4;
        bus_write(8'h00, 32'h1, 4'h1, e);
        repeat (100) @(posedge clk);
        #1;
        check("mid_sens_en", sens_en, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_sens_en", sens_en, 0);
        bus_read(8'h08, rd, e);
        check("rst_mid_status", rd, 0);
        bus_read(8'h0C, rd, e);
        check("rst_mid_result", rd, 0);
        bus_read(8'h04, rd, e);
        check("rst_mid_window", rd, 1000);

`ifdef TSEN_CTRL_AVG_EN
        begin
            int exp_avg [4] = '{2, 5, 8, 11};
            osc_half = 2;
            for (int r = 0; r < 4; r++) begin
                bus_write(8'h04, 32'(40 + 4 * r), 4'hF, e);
                bus_write(8'h00, 32'h1, 4'h1, e);
                wait_idle(300, k);
                check("avg_run_done", (k > 0), 1);
                bus_read(8'h0C, rd, e);
                check("avg_run_result", rd, 32'(10 + r));
                bus_read(8'h18, rd, e);
                check("avg_value", rd, 32'(exp_avg[r]));
                check("avg_err", e, 0);
            end
        end
`else
        bus_read(8'h18, rd, e);
        check("avg_absent_err", e, 1);
        check("avg_absent_rd", rd, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
